// File: rtl/chan_readout_pkg.sv
// Shared definitions for the channel readout sequencer: FSM states and stream word tags.
package chan_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_SPACE,
        WAIT_RO,
        CAPTURE,
        TRAILER,
        FINISH
    } state_t;

    localparam logic [3:0] TAG_HDR = 4'hA;
    localparam logic [3:0] TAG_SMP = 4'h0;
    localparam logic [3:0] TAG_TRL = 4'hE;
    localparam logic [3:0] TAG_TMO = 4'hF;

endpackage

// File: rtl/chan_readout_seq_if.sv
// Output word stream of the readout sequencer: 16-bit valid/ready channel.
interface chan_readout_seq_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/chan_readout_seq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with free-slot count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      free_cnt
);
    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH);
    assign free_cnt = DEPTH - count;
    assign rd_data  = mem[rd_ptr];
    assign do_rd    = rd_en && !empty;
    // A read in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    assign do_wr    = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/chan_readout_seq.sv
// Walks enabled channels in ascending order, framing each channel's captured samples
// as header/samples/trailer into an output FIFO drained over a valid/ready stream.
module chan_readout_seq
    import chan_readout_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WIDTH       = 12,
    parameter int MAX_SAMPLES = 1024,
    parameter int FIFO_AW     = 11,
    parameter int TIMEOUT     = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NCH-1:0]       chan_mask,
    input  logic [NCH-1:0]       ro_enable,
    input  logic [NCH-1:0]       rodone_n,
    input  logic [NCH*WIDTH-1:0] data_in,
    output logic [NCH-1:0]       read_request,
    output logic [NCH-1:0]       spi_done,
    output logic                 busy,
    output logic                 overflow,
    output logic                 timeout_err,
    chan_readout_seq_if.master   stream
);
    localparam int                TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]     TMO_LOAD   = TW'(TIMEOUT - 1);
    localparam logic [FIFO_AW:0]  SPACE_NEED = (FIFO_AW+1)'(MAX_SAMPLES + 2);
    localparam logic [11:0]       MAX_CNT    = 12'(MAX_SAMPLES);

    state_t         state, state_n;
    logic [NCH-1:0] mask_q;
    logic [3:0]     ch_q;
    logic [NCH-1:0] ch_oh;
    logic [3:0]     low_idx;
    logic           req_q;
    logic           ro_q;
    logic           done_seen_q;
    logic [11:0]    cnt_q;
    logic [TW-1:0]  tmo_q;
    logic [7:0]     frame_cnt_q;
    logic           overflow_q;
    logic           timeout_err_q;

    logic           ro_sel;
    logic           done_sel;
    logic [11:0]    smp;
    logic           arm, tmo_hit, push, drop, chan_done;
    logic           wr_en;
    logic [15:0]    wr_data;
    logic [15:0]    fifo_rd_data;
    logic           fifo_empty, fifo_full, fifo_rd, fifo_drop;
    logic [FIFO_AW:0] free_cnt;

    assign ch_oh    = NCH'(1) << ch_q;
    assign ro_sel   = |(ro_enable & ch_oh);
    assign done_sel = |(~rodone_n & ch_oh);

    always_comb begin
        low_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 4'(i);
        end
    end

    always_comb begin
        smp = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_oh[c]) smp = 12'(data_in[c*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        state_n   = state;
        wr_en     = 1'b0;
        wr_data   = '0;
        arm       = 1'b0;
        tmo_hit   = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        chan_done = 1'b0;
        case (state)
            IDLE:       if (start && |chan_mask) state_n = SELECT;
            SELECT:     state_n = (|mask_q) ? WAIT_SPACE : FINISH;
            WAIT_SPACE: if (free_cnt >= SPACE_NEED) begin
                            wr_en   = 1'b1;
                            wr_data = {TAG_HDR, ch_q, frame_cnt_q};
                            arm     = 1'b1;
                            state_n = WAIT_RO;
                        end
            WAIT_RO:    if (ro_sel) begin
                            state_n = CAPTURE;
                        end else if (tmo_q == '0) begin
                            wr_en   = 1'b1;
                            wr_data = {TAG_TMO, ch_q, 8'h00};
                            tmo_hit = 1'b1;
                            state_n = SELECT;
                        end
            // ro_q marks a cycle whose data_in is valid (data trails ro_enable by one cycle)
            CAPTURE:    if (ro_q) begin
                            if (cnt_q < MAX_CNT) begin
                                wr_en   = 1'b1;
                                wr_data = {TAG_SMP, smp};
                                push    = 1'b1;
                            end else begin
                                drop = 1'b1;
                            end
                        end else if (done_seen_q) begin
                            state_n = TRAILER;
                        end
            TRAILER:    begin
                            wr_en     = 1'b1;
                            wr_data   = {TAG_TRL, cnt_q};
                            chan_done = 1'b1;
                            state_n   = SELECT;
                        end
            FINISH:     state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mask_q        <= '0;
            ch_q          <= '0;
            req_q         <= 1'b0;
            ro_q          <= 1'b0;
            done_seen_q   <= 1'b0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            frame_cnt_q   <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state <= state_n;
            ro_q  <= ro_sel;
            if (state == IDLE && state_n == SELECT) mask_q <= chan_mask;
            if (state == SELECT) ch_q <= low_idx;
            if (arm) begin
                req_q       <= 1'b1;
                tmo_q       <= TMO_LOAD;
                cnt_q       <= '0;
                done_seen_q <= 1'b0;
            end else if (state == WAIT_RO && tmo_q != '0) begin
                tmo_q <= tmo_q - TW'(1);
            end
            if (state == CAPTURE && (!ro_sel || done_sel)) done_seen_q <= 1'b1;
            if (push) cnt_q <= cnt_q + 12'd1;
            if (tmo_hit || chan_done) begin
                req_q  <= 1'b0;
                mask_q <= mask_q & ~ch_oh;
            end
            if (tmo_hit) timeout_err_q <= 1'b1;
            if (drop || fifo_drop) overflow_q <= 1'b1;
            if (state == FINISH) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign fifo_rd   = !fifo_empty && stream.out_ready;
    assign fifo_drop = wr_en && fifo_full && !fifo_rd;

    sync_fifo #(.WIDTH(16), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_rd_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .free_cnt (free_cnt)
    );

    assign stream.out_valid = !fifo_empty;
    assign stream.out_data  = fifo_empty ? '0 : fifo_rd_data;

    assign read_request = req_q ? ch_oh : '0;
    assign spi_done     = chan_done ? ch_oh : '0;
    assign busy         = (state != IDLE);
    assign overflow     = overflow_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_chan_readout_seq.sv
// Scoreboard bench for chan_readout_seq: channel models feed samples, a monitor collects the stream.
module tb_chan_readout_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  chan_mask = '0;
    logic [3:0]  ro_enable = '0;
    logic [3:0]  rodone_n = '1;
    logic [47:0] data_in = '0;
    logic [3:0]  read_request;
    logic [3:0]  spi_done;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    chan_readout_seq_if stream ();

    chan_readout_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .chan_mask    (chan_mask),
        .ro_enable    (ro_enable),
        .rodone_n     (rodone_n),
        .data_in      (data_in),
        .read_request (read_request),
        .spi_done     (spi_done),
        .busy         (busy),
        .overflow     (overflow),
        .timeout_err  (timeout_err),
        .stream       (stream)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];
    logic [3:0]  rr_seen;
    int          spi_cnt[4];

    function automatic logic [11:0] smp_val(int c, int i);
        return 12'((c << 8) + 'h111 * (i + 1));
    endfunction

    // Samples at negedge: the values seen here are the ones the next rising edge acts on.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (stream.out_valid && stream.out_ready) act_q.push_back(stream.out_data);
                rr_seen = rr_seen | read_request;
                for (int c = 0; c < 4; c++) if (spi_done[c]) spi_cnt[c]++;
            end
        end
    endtask

    task automatic clear_obs();
        rr_seen = '0;
        for (int c = 0; c < 4; c++) spi_cnt[c] = 0;
    endtask

    task automatic start_frame(input logic [3:0] m);
        @(posedge clk); #1;
        chan_mask = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chan_mask = '0;
    endtask

    // Channel model: waits for its request, then streams n samples with data one cycle behind ro_enable.
    task automatic drive_chan(input int c, input int n, output logic [3:0] rr);
        int k = 0;
        rr = '0;
        do begin @(posedge clk); #1; k++; end while (!read_request[c] && k < 6000);
        rr = read_request;
        if (!read_request[c]) return;
        ro_enable[c] = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_in[c*12 +: 12] = smp_val(c, i);
            if (i < 1024) exp_q.push_back({4'h0, smp_val(c, i)});
            if (i == n - 1) begin
                ro_enable[c] = 1'b0;
                rodone_n[c] = 1'b0;
            end
        end
        @(posedge clk); #1;
        rodone_n[c] = 1'b1;
        data_in[c*12 +: 12] = '0;
        exp_q.push_back({4'hE, 12'((n > 1024) ? 1024 : n)});
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20000) begin @(posedge clk); #1; k++; end
    endtask

    task automatic collect();
        int k = 0;
        while (act_q.size() < exp_q.size() && k < 5000) begin @(posedge clk); #1; k++; end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        total++; if (read_request !== 4'h0) begin bad++; $display("FAIL reset read_request: got %h want 0", read_request); end
        total++; if (spi_done !== 4'h0) begin bad++; $display("FAIL reset spi_done: got %h want 0", spi_done); end
        total++; if (stream.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", stream.out_valid); end
        total++; if (stream.out_data !== 16'h0) begin bad++; $display("FAIL reset out_data: got %h want 0", stream.out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset timeout_err: got %b want 0", timeout_err); end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_zero_mask();
        start_frame(4'b0000);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_mask busy: got %b want 0", busy); end
        repeat (5) begin @(posedge clk); #1; end
        total++; if (stream.out_valid !== 1'b0) begin bad++; $display("FAIL zero_mask out_valid: got %b want 0", stream.out_valid); end
    endtask

    task automatic test_single();
        logic [3:0]  rr;
        logic [15:0] e, a;
        clear_obs();
        exp_q.push_back(16'hA000);
        start_frame(4'b0001);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single busy: got %b want 1", busy); end
        start_frame(4'b1111);
        drive_chan(0, 3, rr);
        total++; if (rr !== 4'b0001) begin bad++; $display("FAIL single read_request: got %h want 1", rr); end
        wait_idle();
        collect();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single busy end: got %b want 0", busy); end
        total++; if (spi_cnt[0] !== 1) begin bad++; $display("FAIL single spi_done0 pulses: got %0d want 1", spi_cnt[0]); end
        total++; if (rr_seen !== 4'b0001) begin bad++; $display("FAIL single requests seen: got %h want 1", rr_seen); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 16'hxxxx;
            total++; if (a !== e) begin bad++; $display("FAIL single word: got %h want %h", a, e); end
        end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL single extra words: got %0d want 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_multi();
        logic [3:0]  rr;
        logic [15:0] e, a;
        clear_obs();
        exp_q.push_back(16'hA101);
        start_frame(4'b1010);
        drive_chan(1, 2, rr);
        total++; if (rr !== 4'b0010) begin bad++; $display("FAIL multi read_request ch1: got %h want 2", rr); end
        exp_q.push_back(16'hA301);
        drive_chan(3, 2, rr);
        total++; if (rr !== 4'b1000) begin bad++; $display("FAIL multi read_request ch3: got %h want 8", rr); end
        wait_idle();
        collect();
        total++; if (rr_seen !== 4'b1010) begin bad++; $display("FAIL multi requests seen: got %h want a", rr_seen); end
        total++; if (spi_cnt[1] !== 1 || spi_cnt[3] !== 1 || spi_cnt[0] !== 0 || spi_cnt[2] !== 0)
            begin bad++; $display("FAIL multi spi_done pulses: got %0d%0d%0d%0d want 1010", spi_cnt[3], spi_cnt[2], spi_cnt[1], spi_cnt[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 16'hxxxx;
            total++; if (a !== e) begin bad++; $display("FAIL multi word: got %h want %h", a, e); end
        end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL multi extra words: got %0d want 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_backpressure();
        logic [3:0]  rr;
        logic [15:0] e, a, hold;
        logic        hold_v;
        int          unstable = 0;
        exp_q.push_back(16'hA002);
        start_frame(4'b0001);
        fork
            drive_chan(0, 1024, rr);
            begin
                repeat (60) @(posedge clk);
                #1;
                stream.out_ready = 1'b0;
                @(negedge clk);
                hold = stream.out_data;
                hold_v = stream.out_valid;
                repeat (50) begin
                    @(negedge clk);
                    if (stream.out_data !== hold || stream.out_valid !== 1'b1) unstable++;
                end
                @(posedge clk); #1;
                stream.out_ready = 1'b1;
            end
        join
        total++; if (rr !== 4'b0001) begin bad++; $display("FAIL backpressure read_request: got %h want 1", rr); end
        total++; if (hold_v !== 1'b1) begin bad++; $display("FAIL backpressure valid at stall: got %b want 1", hold_v); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL backpressure stall stability: got %0d changes want 0", unstable); end
        wait_idle();
        collect();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL backpressure overflow: got %b want 0", overflow); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 16'hxxxx;
            total++; if (a !== e) begin bad++; $display("FAIL backpressure word: got %h want %h", a, e); end
        end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL backpressure extra words: got %0d want 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_timeout();
        logic [3:0]  rr;
        logic [15:0] e, a;
        clear_obs();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout flag before: got %b want 0", timeout_err); end
        exp_q.push_back(16'hA203);
        exp_q.push_back(16'hF200);
        exp_q.push_back(16'hA303);
        start_frame(4'b1100);
        drive_chan(3, 2, rr);
        total++; if (rr !== 4'b1000) begin bad++; $display("FAIL timeout next channel request: got %h want 8", rr); end
        wait_idle();
        collect();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout flag: got %b want 1", timeout_err); end
        total++; if (spi_cnt[2] !== 0 || spi_cnt[3] !== 1) begin bad++; $display("FAIL timeout spi_done: got ch2=%0d ch3=%0d want 0 1", spi_cnt[2], spi_cnt[3]); end
        total++; if (rr_seen !== 4'b1100) begin bad++; $display("FAIL timeout requests seen: got %h want c", rr_seen); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 16'hxxxx;
            total++; if (a !== e) begin bad++; $display("FAIL timeout word: got %h want %h", a, e); end
        end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL timeout extra words: got %0d want 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_overflow();
        logic [3:0]  rr;
        logic [15:0] e, a;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow flag before: got %b want 0", overflow); end
        exp_q.push_back(16'hA004);
        start_frame(4'b0001);
        drive_chan(0, 1030, rr);
        total++; if (rr !== 4'b0001) begin bad++; $display("FAIL overflow read_request: got %h want 1", rr); end
        wait_idle();
        collect();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow flag: got %b want 1", overflow); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 16'hxxxx;
            total++; if (a !== e) begin bad++; $display("FAIL overflow word: got %h want %h", a, e); end
        end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL overflow extra words: got %0d want 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_reset_mid_capture();
        logic [3:0]  rr;
        logic [15:0] e, a;
        start_frame(4'b0001);
        for (int k = 0; k < 100 && !read_request[0]; k++) begin @(posedge clk); #1; end
        total++; if (read_request !== 4'b0001) begin bad++; $display("FAIL midreset request before: got %h want 1", read_request); end
        ro_enable[0] = 1'b1;
        repeat (20) begin @(posedge clk); #1; data_in[11:0] = data_in[11:0] + 12'h005; end
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (read_request !== 4'h0) begin bad++; $display("FAIL midreset read_request: got %h want 0", read_request); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b want 0", busy); end
        total++; if (stream.out_valid !== 1'b0) begin bad++; $display("FAIL midreset out_valid: got %b want 0", stream.out_valid); end
        total++; if (spi_done !== 4'h0) begin bad++; $display("FAIL midreset spi_done: got %h want 0", spi_done); end
        total++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL midreset flags: got %b%b want 00", overflow, timeout_err); end
        ro_enable = '0;
        data_in = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        act_q.delete();
        exp_q.delete();
        clear_obs();
        repeat (3) begin @(posedge clk); #1; end
        exp_q.push_back(16'hA000);
        start_frame(4'b0001);
        drive_chan(0, 2, rr);
        wait_idle();
        collect();
        total++; if (spi_cnt[0] !== 1) begin bad++; $display("FAIL midreset spi_done0 pulses: got %0d want 1", spi_cnt[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 16'hxxxx;
            total++; if (a !== e) begin bad++; $display("FAIL midreset word: got %h want %h", a, e); end
        end
        total++; if (act_q.size() != 0) begin bad++; $display("FAIL midreset extra words: got %0d want 0", act_q.size()); act_q.delete(); end
    endtask

    initial begin
        stream.out_ready = 1'b1;
        clear_obs();
        fork
            monitor_loop();
        join_none
        test_reset();
        test_zero_mask();
        test_single();
        test_multi();
        test_backpressure();
        test_timeout();
        test_overflow();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
